// File: rtl/bus_copy_engine_pkg.sv
// Shared bus defines, error codes and FSM state type
// for the block copy / fill bus initiator.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

package bus_copy_engine_pkg;
    localparam int BUS_W = `BUS_WIDTH;
    localparam int ACC_W = `BUS_ACC_WIDTH;

    localparam logic [ACC_W-1:0] ACC_1B = `BUS_ACC_1B;
    localparam logic [ACC_W-1:0] ACC_2B = `BUS_ACC_2B;
    localparam logic [ACC_W-1:0] ACC_4B = `BUS_ACC_4B;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_FAULT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FIN
    } state_t;

    function automatic logic [BUS_W-1:0] fill_word(
        input logic [7:0] b
    );
        return {(BUS_W/8){b}};
    endfunction
endpackage

// File: rtl/bus_copy_engine_if.sv
// Initiator-side bus: request fields out,
// response / fault / read data back.
interface bus_copy_engine_if #(
    parameter int ADDR_WIDTH = 19
);
    import bus_copy_engine_pkg::*;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  w_rb;
    logic [ACC_W-1:0]      acc;
    logic [BUS_W-1:0]      wdata;
    logic                  req;
    logic [BUS_W-1:0]      rdata;
    logic                  resp;
    logic                  fault;

    modport master (
        output addr, w_rb, acc, wdata, req,
        input  rdata, resp, fault
    );

    modport slave (
        input  addr, w_rb, acc, wdata, req,
        output rdata, resp, fault
    );
endinterface

// File: rtl/bus_acc_sel.sv
// Widest access size that keeps every used
// address naturally aligned and fits in rem.
module bus_acc_sel
    import bus_copy_engine_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic [LEN_WIDTH-1:0] rem,
    input  logic [1:0]           src_lo,
    input  logic [1:0]           dst_lo,
    input  logic                 mode,
    output logic [ACC_W-1:0]     acc,
    output logic [2:0]           k
);
    logic ok4;
    logic ok2;

    always_comb begin
        ok4 = (rem >= LEN_WIDTH'(4))
            && (dst_lo == 2'b00)
            && (mode || (src_lo == 2'b00));
        ok2 = (rem >= LEN_WIDTH'(2))
            && !dst_lo[0]
            && (mode || !src_lo[0]);
        acc = ACC_1B;
        k   = 3'd1;
        priority case (1'b1)
            ok4: begin
                acc = ACC_4B;
                k   = 3'd4;
            end
            ok2: begin
                acc = ACC_2B;
                k   = 3'd2;
            end
            default: begin
                acc = ACC_1B;
                k   = 3'd1;
            end
        endcase
    end
endmodule

// File: rtl/bus_copy_engine.sv
// Ascending block copy / byte fill engine issuing
// one aligned bus access at a time.
module bus_copy_engine
    import bus_copy_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 63
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [7:0]            fill_byte,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    bus_copy_engine_if.master     bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t                state;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [7:0]            fill_q;
    logic [CW-1:0]         cnt;
    logic [2:0]            k_q;
    logic [ACC_W-1:0]      acc_c;
    logic [2:0]            k_c;

    bus_acc_sel #(
        .LEN_WIDTH(LEN_WIDTH)
    ) u_sel (
        .rem   (rem_q),
        .src_lo(src_q[1:0]),
        .dst_lo(dst_q[1:0]),
        .mode  (mode_q),
        .acc   (acc_c),
        .k     (k_c)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_OK;
            bus.req   <= 1'b0;
            bus.w_rb  <= 1'b0;
            bus.addr  <= '0;
            bus.acc   <= ACC_1B;
            bus.wdata <= '0;
            mode_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            fill_q    <= '0;
            cnt       <= '0;
            k_q       <= 3'd1;
        end else begin
            done    <= 1'b0;
            bus.req <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_SETUP;
                        busy   <= 1'b1;
                        err    <= ERR_OK;
                        mode_q <= mode;
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        rem_q  <= len;
                        fill_q <= fill_byte;
                    end
                end
                S_SETUP: begin
                    if (rem_q == '0) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        k_q     <= k_c;
                        bus.acc <= acc_c;
                        bus.req <= 1'b1;
                        if (mode_q) begin
                            state     <= S_WR_REQ;
                            bus.addr  <= dst_q;
                            bus.w_rb  <= 1'b1;
                            bus.wdata <= fill_word(fill_q);
                        end else begin
                            state    <= S_RD_REQ;
                            bus.addr <= src_q;
                            bus.w_rb <= 1'b0;
                        end
                    end
                end
                S_RD_REQ, S_WR_REQ: begin
                    cnt <= '0;
                    if (bus.fault) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        err   <= ERR_FAULT;
                    end else if (state == S_RD_REQ) begin
                        state <= S_RD_WAIT;
                    end else begin
                        state <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // wdata doubles as the read hold register
                    if (bus.resp) begin
                        state     <= S_WR_REQ;
                        bus.req   <= 1'b1;
                        bus.addr  <= dst_q;
                        bus.w_rb  <= 1'b1;
                        bus.wdata <= bus.rdata;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        err   <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WR_WAIT: begin
                    if (bus.resp) begin
                        state <= S_SETUP;
                        src_q <= src_q + ADDR_WIDTH'(k_q);
                        dst_q <= dst_q + ADDR_WIDTH'(k_q);
                        rem_q <= rem_q - LEN_WIDTH'(k_q);
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        err   <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
